// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and the HI/LO result pair used by md_unit, the controller and stall logic.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Width of a down-counter that must hold values 0..max_cycles.
    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are captured at accept; the result lands in HI/LO on the final count.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    md_op_e           op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    hilo_t            result;
    logic             result_valid;
    logic signed [63:0] prod_s;
    logic [63:0]      prod_u;
    logic [31:0]      a_mag, b_mag, q_mag, r_mag;
    logic             b_nonzero;

    // Result datapath, evaluated from the latched operands only.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        result       = '0;
        result_valid = 1'b0;
        b_nonzero    = (b_q != 32'd0);
        prod_s       = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u       = {32'd0, a_q} * {32'd0, b_q};
        a_mag        = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag        = b_q[31] ? (~b_q + 32'd1) : b_q;
        q_mag        = b_nonzero ? (a_mag / b_mag) : 32'd0;
        r_mag        = b_nonzero ? (a_mag % b_mag) : 32'd0;

        unique case (op_q)
            MD_MULT: begin
                result       = prod_s;
                result_valid = 1'b1;
            end
            MD_MULTU: begin
                result       = prod_u;
                result_valid = 1'b1;
            end
            MD_DIV: begin
                // Magnitude divide then re-sign: truncation toward zero, remainder
                // follows the dividend; 0x80000000 / -1 folds to lo=0x80000000, hi=0.
                result.lo    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
                result.hi    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
                result_valid = b_nonzero;
            end
            MD_DIVU: begin
                result.lo    = b_nonzero ? (a_q / b_q) : 32'd0;
                result.hi    = b_nonzero ? (a_q % b_q) : 32'd0;
                result_valid = b_nonzero;
            end
            default: begin
                result       = '0;
                result_valid = 1'b0;
            end
        endcase
    end

    // Next-state: count down while busy, otherwise decide whether to accept.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;

        if (busy_q) begin
            // Any start seen here is dropped; upstream is expected to stall.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && result_valid) begin
                hi_d = result.hi;
                lo_d = result.lo;
            end
        end else if (start) begin
            unique case (md_op)
                MD_MULT, MD_MULTU: begin
                    cnt_d = CNT_W'(MULT_CYCLES);
                    op_d  = md_op_e'(md_op);
                    a_d   = A;
                    b_d   = B;
                end
                MD_DIV, MD_DIVU: begin
                    cnt_d = CNT_W'(DIV_CYCLES);
                    op_d  = md_op_e'(md_op);
                    a_d   = A;
                    b_d   = B;
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            op_q   <= MD_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of HI/LO and busy timing.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cycles_of(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return MULT_N;
            OP_DIV, OP_DIVU:   return DIV_N;
            default:           return 0;
        endcase
    endfunction

    // Architectural effect of one accepted op on HI/LO.
    task automatic ref_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      n, d, q, r;
        logic [63:0] p;
        case (op)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = 64'(a) * 64'(b);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    n = longint'($signed(a));
                    d = longint'($signed(b));
                    q = n / d;
                    r = n % d;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op, check busy/old HI-LO through the busy window, then the result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb);
        int          n;
        logic [31:0] old_hi, old_lo;
        n      = cycles_of(op);
        old_hi = m_hi;
        old_lo = m_lo;
        start  = 1'b1;
        md_op  = op;
        A      = a;
        B      = b;
        tick();
        start = 1'b0;
        ref_apply(op, a, b);
        for (int i = 0; i < n; i++) begin
            check({tag, "/busy"}, 32'(busy), 32'd1);
            check({tag, "/hold_hi"}, hi, old_hi);
            check({tag, "/hold_lo"}, lo, old_lo);
            if (disturb) begin
                start = 1'b1;
                md_op = 4'($urandom_range(0, 15));
                A     = $urandom;
                B     = $urandom;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "/idle"}, 32'(busy), 32'd0);
        check({tag, "/hi"}, hi, m_hi);
        check({tag, "/lo"}, lo, m_lo);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] rop;
        reset = 1'b1;
        start = 1'b0;
        md_op = OP_NONE;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        reset = 1'b0;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/hi", hi, 32'd0);
        check("rst/lo", lo, 32'd0);

        run_op("mult_3x5", OP_MULT, 32'd3, 32'd5, 1'b0);
        check("mult_3x5/lo_lit", lo, 32'd15);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult_neg/hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_neg/lo_lit", lo, 32'hFFFF_FFFE);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu/hi_lit", hi, 32'd1);
        check("multu/lo_lit", lo, 32'hFFFF_FFFE);

        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg/lo_lit", lo, 32'hFFFF_FFFD);
        check("div_neg/hi_lit", hi, 32'hFFFF_FFFF);
        run_op("divu", OP_DIVU, 32'd7, 32'd2, 1'b0);
        check("divu/lo_lit", lo, 32'd3);
        check("divu/hi_lit", hi, 32'd1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf/lo_lit", lo, 32'h8000_0000);
        check("div_ovf/hi_lit", hi, 32'd0);

        // Back-to-back moves.
        start = 1'b1;
        md_op = OP_MTHI;
        A     = 32'h1234;
        tick();
        m_hi = 32'h1234;
        check("mthi/busy", 32'(busy), 32'd0);
        check("mthi/hi", hi, 32'h1234);
        md_op = OP_MTLO;
        A     = 32'h5678;
        tick();
        start = 1'b0;
        m_lo = 32'h5678;
        check("mtlo/busy", 32'(busy), 32'd0);
        check("mtlo/hi", hi, 32'h1234);
        check("mtlo/lo", lo, 32'h5678);

        run_op("div_by0", OP_DIV, 32'd9, 32'd0, 1'b0);
        check("div_by0/hi_lit", hi, 32'h1234);
        check("div_by0/lo_lit", lo, 32'h5678);

        // Start attempts and operand changes during busy must be ignored.
        run_op("mult_disturb", OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("mult_disturb/lo_lit", lo, 32'hFFFF_FFEB);

        // Reset in the 4th busy cycle aborts the divide.
        start = 1'b1;
        md_op = OP_DIV;
        A     = 32'd100;
        B     = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("abort/busy", 32'(busy), 32'd1);
            tick();
        end
        check("abort/busy4", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort/busy_after", 32'(busy), 32'd0);
        check("abort/hi", hi, 32'd0);
        check("abort/lo", lo, 32'd0);
        run_op("after_abort", OP_DIVU, 32'd100, 32'd7, 1'b0);

        // No-op and undefined codes.
        run_op("nop", OP_NONE, 32'hDEAD_BEEF, 32'd1, 1'b0);
        run_op("undef", 4'd12, 32'hDEAD_BEEF, 32'd1, 1'b0);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 8))
                0:       rop = OP_MULT;
                1:       rop = OP_MULTU;
                2:       rop = OP_DIV;
                3:       rop = OP_DIVU;
                4:       rop = OP_MTHI;
                5:       rop = OP_MTLO;
                6:       rop = OP_NONE;
                default: rop = 4'($urandom_range(7, 15));
            endcase
            run_op("rand", rop, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
